// File: rtl/frame_ram_fill_if.sv
// Host write, read and fill-request bundle for frame_ram_fill.
// master drives requests and sees results; slave is the frame RAM side.
interface frame_ram_fill_if #(
    parameter int WordSize    = 8,
    parameter int Rows_Bus    = 10,
    parameter int Columns_Bus = 10
);
    logic                   i_we;
    logic [Rows_Bus-1:0]    i_waddr_row;
    logic [Columns_Bus-1:0] i_waddr_col;
    logic [WordSize-1:0]    i_write;
    logic                   i_re;
    logic [Rows_Bus-1:0]    i_raddr_row;
    logic [Columns_Bus-1:0] i_raddr_col;
    logic [WordSize-1:0]    o_read;
    logic                   o_rvalid;
    logic                   i_fill_start;
    logic [Rows_Bus-1:0]    i_row0;
    logic [Rows_Bus-1:0]    i_row1;
    logic [Columns_Bus-1:0] i_col0;
    logic [Columns_Bus-1:0] i_col1;
    logic [WordSize-1:0]    i_fill_value;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_wr_rejected;

    modport master (
        output i_we, i_waddr_row, i_waddr_col, i_write,
        output i_re, i_raddr_row, i_raddr_col,
        output i_fill_start, i_row0, i_row1, i_col0, i_col1,
        output i_fill_value,
        input  o_read, o_rvalid, o_busy, o_done, o_wr_rejected
    );

    modport slave (
        input  i_we, i_waddr_row, i_waddr_col, i_write,
        input  i_re, i_raddr_row, i_raddr_col,
        input  i_fill_start, i_row0, i_row1, i_col0, i_col1,
        input  i_fill_value,
        output o_read, o_rvalid, o_busy, o_done, o_wr_rejected
    );
endinterface

// File: rtl/frame_ram_fill.sv
// Frame RAM [row][col] with a host write port, 1-cycle read-first read
// port and a rectangle fill engine. Ports: i_clk, i_rst (async, high),
// bus (slave): host write, read request/data, fill request/status.
module frame_ram_fill #(
    parameter int WordSize    = 8,
    parameter int Rows_Bus    = 10,
    parameter int Columns_Bus = 10
) (
    input logic             i_clk,
    input logic             i_rst,
    frame_ram_fill_if.slave bus
);
    localparam int AddrW = Rows_Bus + Columns_Bus;
    localparam int Depth = 2 ** AddrW;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t state;

    logic [WordSize-1:0]    mem [Depth];
    logic [Rows_Bus-1:0]    row_q;
    logic [Rows_Bus-1:0]    row1_q;
    logic [Columns_Bus-1:0] col_q;
    logic [Columns_Bus-1:0] col0_q;
    logic [Columns_Bus-1:0] col1_q;
    logic [WordSize-1:0]    fill_q;

    logic                   mem_we;
    logic [AddrW-1:0]       mem_waddr;
    logic [WordSize-1:0]    mem_wdata;
    logic [AddrW-1:0]       mem_raddr;
    logic                   rect_ok;

    assign mem_raddr = {bus.i_raddr_row, bus.i_raddr_col};
    assign rect_ok   = (bus.i_row0 <= bus.i_row1) &&
                       (bus.i_col0 <= bus.i_col1);

    // The fill engine owns the write port while busy; host writes
    // only land in IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = {bus.i_waddr_row, bus.i_waddr_col};
        mem_wdata = bus.i_write;
        if (state == FILL) begin
            mem_we    = 1'b1;
            mem_waddr = {row_q, col_q};
            mem_wdata = fill_q;
        end else if (state == IDLE) begin
            mem_we = bus.i_we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read samples the array before this edge's write: read-first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_read   <= '0;
            bus.o_rvalid <= 1'b0;
        end else begin
            bus.o_rvalid <= bus.i_re;
            if (bus.i_re) begin
                bus.o_read <= mem[mem_raddr];
            end
        end
    end

    // Counters stop on equality with the latched end corner and never
    // increment past it, so a full-range rectangle cannot wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= IDLE;
            bus.o_busy        <= 1'b0;
            bus.o_done        <= 1'b0;
            bus.o_wr_rejected <= 1'b0;
            row_q             <= '0;
            row1_q            <= '0;
            col_q             <= '0;
            col0_q            <= '0;
            col1_q            <= '0;
            fill_q            <= '0;
        end else begin
            bus.o_wr_rejected <= bus.i_we && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (bus.i_fill_start) begin
                        row_q      <= bus.i_row0;
                        row1_q     <= bus.i_row1;
                        col_q      <= bus.i_col0;
                        col0_q     <= bus.i_col0;
                        col1_q     <= bus.i_col1;
                        fill_q     <= bus.i_fill_value;
                        bus.o_busy <= 1'b1;
                        if (rect_ok) begin
                            state <= FILL;
                        end else begin
                            state      <= DONE;
                            bus.o_done <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (col_q == col1_q) begin
                        if (row_q == row1_q) begin
                            state      <= DONE;
                            bus.o_done <= 1'b1;
                        end else begin
                            row_q <= row_q + 1'b1;
                            col_q <= col0_q;
                        end
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                    bus.o_done <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_ram_fill.sv
// Directed bench for frame_ram_fill: default-size instance for host
// access and fills, 3/3-bit instance for the full-frame fill.
module tb_frame_ram_fill;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    frame_ram_fill_if #(.WordSize(8), .Rows_Bus(10), .Columns_Bus(10)) ba ();
    frame_ram_fill_if #(.WordSize(8), .Rows_Bus(3), .Columns_Bus(3)) bb ();

    frame_ram_fill #(.WordSize(8), .Rows_Bus(10), .Columns_Bus(10)) dut_a (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (ba)
    );

    frame_ram_fill #(.WordSize(8), .Rows_Bus(3), .Columns_Bus(3)) dut_b (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bb)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_a();
        ba.i_we = 0; ba.i_waddr_row = 0; ba.i_waddr_col = 0; ba.i_write = 0;
        ba.i_re = 0; ba.i_raddr_row = 0; ba.i_raddr_col = 0;
        ba.i_fill_start = 0; ba.i_row0 = 0; ba.i_row1 = 0;
        ba.i_col0 = 0; ba.i_col1 = 0; ba.i_fill_value = 0;
    endtask

    task automatic clr_b();
        bb.i_we = 0; bb.i_waddr_row = 0; bb.i_waddr_col = 0; bb.i_write = 0;
        bb.i_re = 0; bb.i_raddr_row = 0; bb.i_raddr_col = 0;
        bb.i_fill_start = 0; bb.i_row0 = 0; bb.i_row1 = 0;
        bb.i_col0 = 0; bb.i_col1 = 0; bb.i_fill_value = 0;
    endtask

    task automatic wr_a(input int r, input int c, input logic [7:0] d);
        ba.i_we = 1; ba.i_waddr_row = 10'(r); ba.i_waddr_col = 10'(c);
        ba.i_write = d;
        tick();
        ba.i_we = 0;
    endtask

    task automatic rd_a(input string tag, input int r, input int c,
                        input logic [7:0] e);
        ba.i_re = 1; ba.i_raddr_row = 10'(r); ba.i_raddr_col = 10'(c);
        tick();
        ba.i_re = 0;
        chk({tag, ".rvalid"}, 32'(ba.o_rvalid), 1);
        chk(tag, 32'(ba.o_read), 32'(e));
    endtask

    task automatic rd_b(input string tag, input int r, input int c,
                        input logic [7:0] e);
        bb.i_re = 1; bb.i_raddr_row = 3'(r); bb.i_raddr_col = 3'(c);
        tick();
        bb.i_re = 0;
        chk(tag, {23'd0, bb.o_rvalid, bb.o_read}, {23'd1, e});
    endtask

    // Start a fill, then scramble the request inputs so a design that
    // does not latch them at acceptance shows it.
    task automatic fill_a(input int r0, input int r1, input int c0,
                          input int c1, input logic [7:0] v);
        ba.i_fill_start = 1;
        ba.i_row0 = 10'(r0); ba.i_row1 = 10'(r1);
        ba.i_col0 = 10'(c0); ba.i_col1 = 10'(c1);
        ba.i_fill_value = v;
        tick();
        ba.i_fill_start = 0;
        ba.i_row0 = 10'd0; ba.i_row1 = 10'd1023;
        ba.i_col0 = 10'd0; ba.i_col1 = 10'd1023;
        ba.i_fill_value = ~v;
    endtask

    task automatic wait_a(output int bc, output int dc);
        bc = 0;
        dc = 0;
        for (int i = 0; i < 200 && ba.o_busy; i++) begin
            bc++;
            if (ba.o_done) dc++;
            tick();
        end
        chk("a_idle_in_bound", 32'(ba.o_busy), 0);
    endtask

    initial begin
        int bc;
        int dc;
        clr_a();
        clr_b();
        ba.i_we = 1;
        ba.i_re = 1;
        #1;
        chk("rst_busy", 32'(ba.o_busy), 0);
        chk("rst_done", 32'(ba.o_done), 0);
        chk("rst_rvalid", 32'(ba.o_rvalid), 0);
        chk("rst_read", 32'(ba.o_read), 0);
        chk("rst_busy_b", 32'(bb.o_busy), 0);
        clr_a();
        tick();
        rst = 0;
        tick();

        // Host write then read next cycle.
        wr_a(3, 7, 8'hA5);
        rd_a("rd_3_7", 3, 7, 8'hA5);
        tick();
        chk("rvalid_drop", 32'(ba.o_rvalid), 0);
        chk("read_hold", 32'(ba.o_read), 32'hA5);

        // Same-cycle write and read of one cell returns old data.
        ba.i_we = 1; ba.i_waddr_row = 3; ba.i_waddr_col = 7;
        ba.i_write = 8'h11;
        ba.i_re = 1; ba.i_raddr_row = 3; ba.i_raddr_col = 7;
        tick();
        clr_a();
        chk("read_first", 32'(ba.o_read), 32'hA5);
        rd_a("rd_after_wr", 3, 7, 8'h11);

        // Fill rows 2..3, cols 5..6 with 0x3C.
        wr_a(2, 4, 8'h01);
        wr_a(2, 7, 8'h02);
        wr_a(4, 5, 8'h03);
        wr_a(2, 5, 8'h0F);
        fill_a(2, 3, 5, 6, 8'h3C);
        chk("fill_busy_up", 32'(ba.o_busy), 1);
        wait_a(bc, dc);
        chk("fill_busy_cycles", 32'(bc), 5);
        chk("fill_done_pulses", 32'(dc), 1);
        rd_a("f_2_5", 2, 5, 8'h3C);
        rd_a("f_2_6", 2, 6, 8'h3C);
        rd_a("f_3_5", 3, 5, 8'h3C);
        rd_a("f_3_6", 3, 6, 8'h3C);
        rd_a("f_2_4", 2, 4, 8'h01);
        rd_a("f_2_7", 2, 7, 8'h02);
        rd_a("f_4_5", 4, 5, 8'h03);

        // Inverted rectangles: DONE next cycle, nothing written.
        wr_a(5, 3, 8'h44);
        wr_a(4, 3, 8'h45);
        fill_a(5, 4, 3, 3, 8'hEE);
        chk("inv_busy", 32'(ba.o_busy), 1);
        chk("inv_done", 32'(ba.o_done), 1);
        tick();
        chk("inv_idle", 32'(ba.o_busy), 0);
        chk("inv_done_drop", 32'(ba.o_done), 0);
        fill_a(4, 4, 6, 2, 8'hEE);
        chk("invc_done", 32'(ba.o_done), 1);
        tick();
        rd_a("inv_5_3", 5, 3, 8'h44);
        rd_a("inv_4_3", 4, 3, 8'h45);
        rd_a("invc_4_3", 4, 3, 8'h45);

        // Host write and fill request while busy are dropped.
        wr_a(0, 0, 8'h5A);
        wr_a(11, 10, 8'h66);
        fill_a(10, 11, 0, 9, 8'hB2);
        ba.i_we = 1; ba.i_waddr_row = 0; ba.i_waddr_col = 0;
        ba.i_write = 8'hFF;
        ba.i_fill_start = 1;
        ba.i_row0 = 0; ba.i_row1 = 0; ba.i_col0 = 0; ba.i_col1 = 0;
        ba.i_fill_value = 8'h77;
        tick();
        ba.i_we = 0;
        ba.i_fill_start = 0;
        chk("wr_rej_pulse", 32'(ba.o_wr_rejected), 1);
        rd_a("rd_in_fill", 3, 7, 8'h11);
        chk("wr_rej_drop", 32'(ba.o_wr_rejected), 0);
        wait_a(bc, dc);
        chk("busy_fill_cycles", 32'(bc), 19);
        chk("busy_fill_done", 32'(dc), 1);
        rd_a("rej_0_0", 0, 0, 8'h5A);
        rd_a("b_10_0", 10, 0, 8'hB2);
        rd_a("b_11_9", 11, 9, 8'hB2);
        rd_a("b_11_10", 11, 10, 8'h66);

        // Reset after three writes of a 1x8 row fill.
        for (int c = 0; c < 8; c++) wr_a(7, c, 8'(8'h80 + c));
        fill_a(7, 7, 0, 7, 8'hC3);
        tick();
        tick();
        tick();
        rst = 1;
        #1;
        chk("abort_busy", 32'(ba.o_busy), 0);
        chk("abort_done", 32'(ba.o_done), 0);
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", {30'd0, ba.o_busy, ba.o_done}, 0);
        end
        for (int c = 0; c < 8; c++) begin
            rd_a("abort_cell", 7, c, (c < 3) ? 8'hC3 : 8'(8'h80 + c));
        end

        // Full-frame fill on the 8x8 instance.
        bb.i_fill_start = 1;
        bb.i_row0 = 0; bb.i_row1 = 7; bb.i_col0 = 0; bb.i_col1 = 7;
        bb.i_fill_value = 8'h9D;
        tick();
        clr_b();
        bc = 0;
        dc = 0;
        for (int i = 0; i < 200 && bb.o_busy; i++) begin
            bc++;
            if (bb.o_done) dc++;
            tick();
        end
        chk("full_idle_in_bound", 32'(bb.o_busy), 0);
        chk("full_busy_cycles", 32'(bc), 65);
        chk("full_done_pulses", 32'(dc), 1);
        bb.i_we = 1; bb.i_waddr_row = 2; bb.i_waddr_col = 3;
        bb.i_write = 8'h12;
        tick();
        bb.i_we = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                rd_b("full_cell", r, c,
                     (r == 2 && c == 3) ? 8'h12 : 8'h9D);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/frame_ram_fill.md
FRAME_RAM_FILL -- requirements
Module: frame_ram_fill

Interface
REQ-001 SHALL have parameter WordSize, default 8, pixel word width in bits.
REQ-002 SHALL have parameter Rows_Bus, default 10, row address width; depth 2**Rows_Bus rows.
REQ-003 SHALL have parameter Columns_Bus, default 10, column address width; 2**Columns_Bus columns.
REQ-004 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_we  input  1  host write strobe.
REQ-007 SHALL have ports i_waddr_row / i_waddr_col  input  Rows_Bus / Columns_Bus  host write address.
REQ-008 SHALL have port i_write  input  WordSize  host write data.
REQ-009 SHALL have port i_re  input  1  read request.
REQ-010 SHALL have ports i_raddr_row / i_raddr_col  input  Rows_Bus / Columns_Bus  read address.
REQ-011 SHALL have port o_read  output  WordSize  registered read data.
REQ-012 SHALL have port o_rvalid  output  1  o_read valid pulse.
REQ-013 SHALL have port i_fill_start  input  1  fill request, sampled only in IDLE.
REQ-014 SHALL have ports i_row0, i_row1 (Rows_Bus) and i_col0, i_col1 (Columns_Bus)  input  inclusive fill rectangle corners.
REQ-015 SHALL have port i_fill_value  input  WordSize  fill word.
REQ-016 SHALL have port o_busy  output  1  fill engine active.
REQ-017 SHALL have port o_done  output  1  one-cycle fill completion pulse.
REQ-018 SHALL have port o_wr_rejected  output  1  one-cycle pulse: host write dropped.

Function
REQ-019 SHALL store 2**Rows_Bus x 2**Columns_Bus words, addressed [row][col]; memory contents are not reset.
REQ-020 SHALL, when i_re=1 at edge N, drive o_read with the addressed word and o_rvalid=1 after edge N (1-cycle latency); o_rvalid=0 otherwise, o_read holds its last value.
REQ-021 SHALL return old data (read-first) when read and any write hit the same cell in the same cycle.
REQ-022 SHALL write i_write to the host address at the edge where i_we=1 and state is IDLE.
REQ-023 SHALL have FSM states IDLE, FILL, DONE.
REQ-024 SHALL, in IDLE with i_fill_start=1, latch rectangle and i_fill_value; go to FILL if i_row0<=i_row1 and i_col0<=i_col1, else go directly to DONE with no writes.
REQ-025 SHALL, in FILL, write one cell per cycle in raster order: column increments from col0 to col1, then wraps to col0 with row+1; first write at (row0,col0) in the first FILL cycle.
REQ-026 SHALL leave FILL for DONE after the write of (row1,col1); total writes = (row1-row0+1)*(col1-col0+1), duration equal to that many cycles.
REQ-027 SHALL hold DONE exactly one cycle with o_done=1, then return to IDLE.
REQ-028 SHALL assert o_busy in FILL and DONE, 0 in IDLE.
REQ-029 SHALL ignore i_fill_start while o_busy=1; inputs changing after acceptance do not affect the fill.
REQ-030 SHALL, when i_we=1 while o_busy=1, drop the host write and pulse o_wr_rejected=1 the following cycle.
REQ-031 SHALL use counters wide enough that row1=2**Rows_Bus-1 and col1=2**Columns_Bus-1 terminate without wrap-around overrun.
REQ-032 SHALL keep serving reads during a fill (fill writes follow REQ-021).

Reset
REQ-033 SHALL on i_rst=1, immediately: state IDLE, o_busy=0, o_done=0, o_rvalid=0, o_wr_rejected=0, o_read=0.
REQ-034 SHALL abort an in-progress fill on reset; cells already written keep fill value, remaining cells untouched; no o_done pulse.

Verification
REQ-035 SHALL cover: write 0xA5 to (3,7), i_re at (3,7) next cycle -> o_rvalid=1 and o_read=0xA5 one cycle later.
REQ-036 SHALL cover: fill rows 2..3, cols 5..6 with 0x3C -> o_busy for 5 cycles, 4 writes, o_done once; (2,4),(2,7),(4,5) unchanged, all four cells read 0x3C.
REQ-037 SHALL cover: fill with i_row0=5, i_row1=4 -> DONE next cycle, o_done pulse, no cell modified.
REQ-038 SHALL cover: i_we at (0,0) during fill -> o_wr_rejected pulse, (0,0) keeps prior value; i_fill_start during fill ignored.
REQ-039 SHALL cover: reset asserted after 3 fill writes of 1x8 row -> o_busy=0 at once, first 3 cells hold fill value, rest unchanged, no o_done.
REQ-040 SHALL cover: full-frame fill (0,0)-(max,max) with small parameters (Rows_Bus=Columns_Bus=3) -> exactly 64 writes, clean return to IDLE.
